// File: rtl/lfsr_seq_ctrl.sv
// Run controller for a 4-bit LFSR: loads a seed, advances it once per tick for a
// requested number of steps and records the first return-to-seed distance.
module lfsr_seq_ctrl #(
    parameter int unsigned NSTEP_W = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               start,
    input  logic [3:0]         seed,
    input  logic [NSTEP_W-1:0] nsteps,
    input  logic               tick,
    output logic [3:0]         state,
    output logic [NSTEP_W-1:0] step_cnt,
    output logic [3:0]         period,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [3:0]         lfsr_q, lfsr_d;
    logic [3:0]         seed_q, seed_d;
    logic [3:0]         per_q, per_d;
    logic [NSTEP_W-1:0] cnt_q, cnt_d;
    logic [NSTEP_W-1:0] nsteps_q, nsteps_d;
    logic               err_q, err_d;

    logic [3:0]         lfsr_nxt;
    logic [NSTEP_W-1:0] cnt_inc;

    assign lfsr_nxt = {lfsr_q[1] ^ lfsr_q[0], lfsr_q[3:1]};
    assign cnt_inc  = cnt_q + NSTEP_W'(1);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            fsm_q    <= StIdle;
            lfsr_q   <= 4'd0;
            seed_q   <= 4'd0;
            per_q    <= 4'd0;
            cnt_q    <= '0;
            nsteps_q <= '0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            per_q    <= per_d;
            cnt_q    <= cnt_d;
            nsteps_q <= nsteps_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        per_d    = per_q;
        cnt_d    = cnt_q;
        nsteps_d = nsteps_q;
        err_d    = err_q;

        case (fsm_q)
            StIdle: begin
                if (start) begin
                    if (seed != 4'd0) begin
                        seed_d   = seed;
                        nsteps_d = nsteps;
                        err_d    = 1'b0;
                        fsm_d    = StLoad;
                    end else begin
                        // An all-zero seed would lock the LFSR, so refuse the run.
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                lfsr_d = seed_q;
                cnt_d  = '0;
                per_d  = 4'd0;
                fsm_d  = (nsteps_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (tick) begin
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_inc;
                    if ((lfsr_nxt == seed_q) && (per_q == 4'd0)) begin
                        per_d = cnt_inc[3:0];
                    end
                    if (cnt_inc == nsteps_q) begin
                        fsm_d = StDone;
                    end
                end
            end
            StDone: begin
                fsm_d = StIdle;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    assign state    = lfsr_q;
    assign step_cnt = cnt_q;
    assign period   = per_q;
    assign err      = err_q;
    assign busy     = (fsm_q == StLoad) || (fsm_q == StRun);
    assign done     = (fsm_q == StDone);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: per-cycle model of the LFSR run plus a
// scoreboard of final run results popped on each done pulse.
module tb_lfsr_seq_ctrl;

    localparam int NW = 8;

    logic          clk;
    logic          RST;
    logic          start;
    logic [3:0]    seed;
    logic [NW-1:0] nsteps;
    logic          tick;
    logic [3:0]    state;
    logic [NW-1:0] step_cnt;
    logic [3:0]    period;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic [3:0]    st;
        logic [NW-1:0] cnt;
        logic [3:0]    per;
        int            lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]    last_st;
    logic [NW-1:0] last_cnt;
    logic [3:0]    last_per;

    lfsr_seq_ctrl #(.NSTEP_W(NW)) dut (
        .clk      (clk),
        .RST      (RST),
        .start    (start),
        .seed     (seed),
        .nsteps   (nsteps),
        .tick     (tick),
        .state    (state),
        .step_cnt (step_cnt),
        .period   (period),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[1] ^ s[0], s[3:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start in the current cycle and follows the run cycle by cycle.
    task automatic run(input logic [3:0] sd, input int ns, input int every, input bit inject);
        exp_t          e;
        logic [3:0]    m;
        logic [3:0]    mp;
        logic [NW-1:0] mc;
        int            lat;
        bit            seen;

        m  = sd;
        mp = 4'd0;
        for (int i = 1; i <= ns; i++) begin
            m = lfsr_next(m);
            if (m == sd && mp == 4'd0) mp = 4'(i);
        end
        e.st  = m;
        e.cnt = NW'(ns);
        e.per = mp;
        e.lat = (ns == 0) ? 2 : 3 + (ns - 1) * every;
        sb.push_back(e);
        lat = e.lat;

        seed   = sd;
        nsteps = NW'(ns);
        start  = 1'b1;
        tick   = 1'b0;
        m      = sd;
        mp     = 4'd0;
        mc     = '0;
        seen   = 1'b0;

        for (int c = 1; c <= lat + 4 && !seen; c++) begin
            step();
            check("busy", 32'(busy), 32'(c < lat));
            check("done", 32'(done), 32'(c == lat));
            check("err", 32'(err), 32'(0));
            if (c >= 2) begin
                check("state", 32'(state), 32'(m));
                check("step_cnt", 32'(step_cnt), 32'(mc));
                check("period", 32'(period), 32'(mp));
            end
            if (done) begin
                e = sb.pop_front();
                check("sb_state", 32'(state), 32'(e.st));
                check("sb_step_cnt", 32'(step_cnt), 32'(e.cnt));
                check("sb_period", 32'(period), 32'(e.per));
                check("sb_latency", 32'(c), 32'(e.lat));
                seen  = 1'b1;
                start = 1'b0;
                tick  = 1'b0;
            end else begin
                tick = (c >= 2) && ((c - 2) % every == 0);
                if (tick && int'(mc) < ns) begin
                    m  = lfsr_next(m);
                    mc = mc + NW'(1);
                    if (m == sd && mp == 4'd0) mp = mc[3:0];
                end
                if (inject) begin
                    start  = (c % 2 == 1);
                    seed   = 4'(c);
                    nsteps = NW'(c + 7);
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        start = 1'b0;
        step();
        check("post_done", 32'(done), 32'(0));
        check("post_busy", 32'(busy), 32'(0));
        check("post_state", 32'(state), 32'(m));
        check("post_step_cnt", 32'(step_cnt), 32'(mc));
        check("post_period", 32'(period), 32'(mp));
        last_st  = m;
        last_cnt = mc;
        last_per = mp;
    endtask

    initial begin
        RST    = 1'b1;
        start  = 1'b0;
        seed   = 4'd0;
        nsteps = '0;
        tick   = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(0));
        check("rst_step_cnt", 32'(step_cnt), 32'(0));
        check("rst_period", 32'(period), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        step();
        step();
        RST = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'(0));

        run(4'b1000, 3, 1, 1'b0);
        run(4'b1000, 20, 1, 1'b0);

        // Zero seed must be refused and leave the previous results intact.
        seed  = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zs_err", 32'(err), 32'(1));
        check("zs_busy", 32'(busy), 32'(0));
        check("zs_done", 32'(done), 32'(0));
        check("zs_state", 32'(state), 32'(last_st));
        check("zs_step_cnt", 32'(step_cnt), 32'(last_cnt));
        check("zs_period", 32'(period), 32'(last_per));
        step();
        check("zs_err_hold", 32'(err), 32'(1));
        check("zs_done_hold", 32'(done), 32'(0));
        run(4'b0001, 5, 1, 1'b0);

        run(4'b0101, 0, 1, 1'b0);
        run(4'b0001, 2, 4, 1'b1);

        // Abort a run with an asynchronous reset after two advances.
        seed   = 4'b1000;
        nsteps = NW'(10);
        tick   = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("ab_step_cnt", 32'(step_cnt), 32'(2));
        check("ab_state", 32'(state), 32'(4'b0010));
        #2;
        RST = 1'b1;
        #1;
        check("ab_rst_state", 32'(state), 32'(0));
        check("ab_rst_step_cnt", 32'(step_cnt), 32'(0));
        check("ab_rst_period", 32'(period), 32'(0));
        check("ab_rst_busy", 32'(busy), 32'(0));
        check("ab_rst_done", 32'(done), 32'(0));
        step();
        check("ab_hold_done", 32'(done), 32'(0));
        check("ab_hold_state", 32'(state), 32'(0));
        RST  = 1'b0;
        tick = 1'b0;
        step();
        check("ab_idle_busy", 32'(busy), 32'(0));
        check("ab_idle_done", 32'(done), 32'(0));
        run(4'b0011, 4, 2, 1'b0);

        run(4'b1000, 255, 1, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
